// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The checksum width only matters when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_CHK   = 3'd3,
      S_DONE  = 3'd4
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
   localparam int CKSUM_W        = 8;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; word_full_o fires with the 4th byte.
// Zero latency on word_full_o; the packed word is valid the cycle after that byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [BIDX_W-1:0] idx_q, idx_d;
   logic [31:0]       word_q, word_d;

   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (accept_i) begin
         idx_d = idx_q + 1'b1;
         case (idx_q)
            2'd0:    word_d[31:24] = byte_i;
            2'd1:    word_d[23:16] = byte_i;
            2'd2:    word_d[15:8]  = byte_i;
            default: word_d[7:0]   = byte_i;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   assign word_o      = word_q;
   assign word_full_o = accept_i && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory from word 0, holding the core in reset until a clean load.
// 5 cycles per word with continuous s_valid_i; optional trailing checksum byte under IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W:0]   word_count_i,
   input  logic              s_valid_i,
   input  logic [7:0]        s_data_i,
   output logic              s_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_rst_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

   loader_state_t     state_q, state_d;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_clamped;
   logic [ADDR_W:0]   addr_inc;
   logic [ADDR_W-1:0] addr_q;
   logic              cpu_rst_n_q;
   logic              start_acc;
   logic              accept;
   logic              load_acc;
   logic              last_word;
   logic              word_full;

   assign start_acc     = start_i && (state_q == S_IDLE);
   assign accept        = s_valid_i && s_ready_o;
   assign load_acc      = accept && (state_q == S_LOAD);
   assign count_clamped = (word_count_i > MAX_WORDS) ? MAX_WORDS : word_count_i;
   assign addr_inc      = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign last_word     = (addr_inc == count_q);

   byte_packer u_packer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clear_i     (start_acc),
      .accept_i    (load_acc),
      .byte_i      (s_data_i),
      .word_o      (imem_wdata_o),
      .word_full_o (word_full)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_acc) state_d = (count_clamped == '0) ? S_DONE : S_LOAD;
         S_LOAD:  if (word_full) state_d = S_WRITE;
         S_WRITE: begin
            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHK:   if (accept) state_d = S_DONE;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      s_ready_o = (state_q == S_LOAD) || (state_q == S_CHK);
      imem_we_o = (state_q == S_WRITE);
      busy_o    = (state_q != S_IDLE);
      done_o    = (state_q == S_DONE);
   end

   // The final address is not advanced, so a full-capacity load never wraps.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q     <= '0;
         addr_q      <= '0;
         cpu_rst_n_q <= 1'b0;
      end else begin
         if (start_acc) begin
            count_q     <= count_clamped;
            addr_q      <= '0;
            cpu_rst_n_q <= 1'b0;
         end
         if ((state_q == S_WRITE) && !last_word) addr_q <= addr_q + 1'b1;
         if ((state_q == S_DONE) && !err_o) cpu_rst_n_q <= 1'b1;
      end
   end

   assign imem_addr_o = addr_q;
   assign cpu_rst_n_o = cpu_rst_n_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [CKSUM_W-1:0] cksum_q;
   logic [CKSUM_W-1:0] cksum_total;
   logic               err_q;

   assign cksum_total = cksum_q + s_data_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cksum_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (start_acc) begin
            cksum_q <= '0;
            err_q   <= 1'b0;
         end else if (load_acc) begin
            cksum_q <= cksum_total;
         end else if (accept && (state_q == S_CHK) && (cksum_total != '0)) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write log, done/release timing, gaps, reset abort, clamp, checksum.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] word_count = '0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = '0;
   logic       s_ready, imem_we, cpu_rst_n, busy, done, err;
   logic [7:0] imem_addr;
   logic [31:0] imem_wdata;

   imem_loader #(.ADDR_W(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .word_count_i (word_count),
      .s_valid_i    (s_valid),
      .s_data_i     (s_data),
      .s_ready_o    (s_ready),
      .imem_we_o    (imem_we),
      .imem_addr_o  (imem_addr),
      .imem_wdata_o (imem_wdata),
      .cpu_rst_n_o  (cpu_rst_n),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   rel_cyc = 0;
   int   rdy_viol = 0;
   logic prev_cpu = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back({24'h0, imem_addr});
         wd.push_back(imem_wdata);
         if (s_ready) rdy_viol <= rdy_viol + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (cpu_rst_n && !prev_cpu) rel_cyc <= cyc;
      prev_cpu <= cpu_rst_n;
   end

   int         t0;
   int         d_base;
   int         w_base;
   logic [7:0] sum8;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"}, {31'h0, s_ready}, 32'h0);
      chk({tag, "_we"}, {31'h0, imem_we}, 32'h0);
      chk({tag, "_addr"}, {24'h0, imem_addr}, 32'h0);
      chk({tag, "_wdata"}, imem_wdata, 32'h0);
      chk({tag, "_cpu_rst_n"}, {31'h0, cpu_rst_n}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_done"}, {31'h0, done}, 32'h0);
      chk({tag, "_err"}, {31'h0, err}, 32'h0);
   endtask

   // Entered and left on a negedge; t0 is the cycle in which start is high.
   task automatic do_start(input logic [8:0] n);
      start      = 1'b1;
      word_count = n;
      t0         = cyc;
      d_base     = done_cnt;
      w_base     = wa.size();
      sum8       = 8'h00;
      @(negedge clk);
      start      = 1'b0;
      word_count = '0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      for (int i = 0; i < gap; i++) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("ready_wait", {31'h0, s_ready}, 32'h1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      sum8 = sum8 + b;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
   endtask

   task automatic send_ck(input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0] c;
      c = 8'h00 - sum8;
      send_byte(c, gap);
`else
      if (gap < 0) s_valid = 1'b0;
`endif
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_cnt == d_base && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done_cnt == d_base) chk("done_timeout", done_cnt, d_base + 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int bad;
      logic [31:0] exp_w;

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Two words, continuous stream
      do_start(9'd2);
      chk("t1_busy", {31'h0, busy}, 32'h1);
      chk("t1_cpu_held", {31'h0, cpu_rst_n}, 32'h0);
      send_word(32'h20080005, 0);
      send_word(32'h8C090004, 0);
      send_ck(0);
      wait_done(50);
      chk("t1_nwrites", wa.size() - w_base, 32'd2);
      chk("t1_addr0", wa[w_base], 32'h0);
      chk("t1_data0", wd[w_base], 32'h20080005);
      chk("t1_addr1", wa[w_base+1], 32'h1);
      chk("t1_data1", wd[w_base+1], 32'h8C090004);
      chk("t1_done_cycle", done_cyc - t0, 11 + CK);
      chk("t1_release_cycle", rel_cyc - t0, 12 + CK);
      chk("t1_done_pulses", done_cnt - d_base, 32'd1);
      chk("t1_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h1);
      chk("t1_busy_idle", {31'h0, busy}, 32'h0);
      chk("t1_err", {31'h0, err}, 32'h0);

      // Same load with 3-cycle valid gaps between bytes
      do_start(9'd2);
      send_word(32'h20080005, 3);
      send_word(32'h8C090004, 3);
      send_ck(3);
      wait_done(200);
      chk("t2_nwrites", wa.size() - w_base, 32'd2);
      chk("t2_addr0", wa[w_base], 32'h0);
      chk("t2_data0", wd[w_base], 32'h20080005);
      chk("t2_addr1", wa[w_base+1], 32'h1);
      chk("t2_data1", wd[w_base+1], 32'h8C090004);
      chk("t2_ready_in_write", rdy_viol, 32'd0);
      chk("t2_done_pulses", done_cnt - d_base, 32'd1);
      chk("t2_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h1);

      // Zero-word load
      do_start(9'd0);
      chk("t3_done_now", {31'h0, done}, 32'h1);
      chk("t3_cpu_held", {31'h0, cpu_rst_n}, 32'h0);
      @(negedge clk);
      chk("t3_done_gone", {31'h0, done}, 32'h0);
      chk("t3_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h1);
      chk("t3_busy", {31'h0, busy}, 32'h0);
      repeat (2) @(negedge clk);
      chk("t3_nwrites", wa.size() - w_base, 32'd0);
      chk("t3_done_pulses", done_cnt - d_base, 32'd1);

      // Start pulsed mid-LOAD must be ignored
      do_start(9'd1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      start = 1'b1;
      word_count = 9'd3;
      @(negedge clk);
      start = 1'b0;
      word_count = '0;
      chk("t5_busy", {31'h0, busy}, 32'h1);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_ck(0);
      wait_done(50);
      chk("t5_nwrites", wa.size() - w_base, 32'd1);
      chk("t5_addr0", wa[w_base], 32'h0);
      chk("t5_data0", wd[w_base], 32'h11223344);
      chk("t5_done_pulses", done_cnt - d_base, 32'd1);
      chk("t5_busy_idle", {31'h0, busy}, 32'h0);

      // Reset after 6 bytes of a 3-word load
      do_start(9'd3);
      send_word(32'hCAFEF00D, 0);
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_vals("t4_abort");
      repeat (5) @(negedge clk);
      chk("t4_nwrites", wa.size() - w_base, 32'd1);
      chk("t4_data0", wd[w_base], 32'hCAFEF00D);
      rst_n = 1'b1;
      @(negedge clk);
      do_start(9'd1);
      send_word(32'h01234567, 0);
      send_ck(0);
      wait_done(50);
      chk("t4_reload_nwrites", wa.size() - w_base, 32'd1);
      chk("t4_reload_addr", wa[w_base], 32'h0);
      chk("t4_reload_data", wd[w_base], 32'h01234567);
      chk("t4_reload_cpu", {31'h0, cpu_rst_n}, 32'h1);

      // Oversized count clamps to 256 words
      do_start(9'h1FF);
      for (int i = 0; i < 256; i++) send_word({i[7:0], ~i[7:0], 8'hA5, 8'h3C}, 0);
      send_ck(0);
      wait_done(3000);
      chk("t6_nwrites", wa.size() - w_base, 32'd256);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         exp_w = {i[7:0], ~i[7:0], 8'hA5, 8'h3C};
         if (wa[w_base+i] !== 32'(i) || wd[w_base+i] !== exp_w) bad++;
      end
      chk("t6_bad_writes", bad, 32'd0);
      chk("t6_last_addr", wa[w_base+255], 32'd255);
      chk("t6_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      do_start(9'd1);
      send_word(32'h00000001, 0);
      send_byte(8'hFF, 0);
      wait_done(50);
      chk("ck_good_err", {31'h0, err}, 32'h0);
      chk("ck_good_cpu", {31'h0, cpu_rst_n}, 32'h1);
      do_start(9'd1);
      send_word(32'h00000001, 0);
      send_byte(8'h00, 0);
      wait_done(50);
      chk("ck_bad_err", {31'h0, err}, 32'h1);
      chk("ck_bad_cpu", {31'h0, cpu_rst_n}, 32'h0);
      repeat (4) @(negedge clk);
      chk("ck_bad_err_sticky", {31'h0, err}, 32'h1);
      do_start(9'd0);
      chk("ck_err_cleared", {31'h0, err}, 32'h0);
      repeat (2) @(negedge clk);
      chk("ck_cpu_after_clear", {31'h0, cpu_rst_n}, 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
